vortex_mem_slave: RTL and testbench



---
 rtl/vortex_mem_slave_pkg.sv | 18 +
 rtl/vortex_mem_slave_array.sv | 26 ++
 rtl/vortex_mem_slave.sv | 139 +++++++++++++
 tb/tb_vortex_mem_slave.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/vortex_mem_slave_pkg.sv
// Shared types and constants for the vortex_mem_slave scratch memory.
package vortex_mem_slave_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } req_kind_t;

  localparam int unsigned MEM_WORDS = (2 ** 14) / 4;
  localparam int unsigned LAT_W     = 4;

endpackage

// File: rtl/vortex_mem_slave_array.sv
// Word array: synchronous byte-enabled write, combinational read.
module vortex_mem_slave_array #(
  parameter int unsigned AW = 12
) (
  input  logic          CLK,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] r_mem [2**AW];

  always_ff @(posedge CLK) begin
    if (we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be[b]) r_mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/vortex_mem_slave.sv
// Bus peripheral scratch memory with programmable read/write wait states
// and error reporting for out-of-range, misaligned or conflicting requests.
module vortex_mem_slave
  import vortex_mem_slave_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned MEM_BYTE_WIDTH = 14,
  parameter int unsigned READ_LATENCY   = 2,
  parameter int unsigned WRITE_LATENCY  = 1
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic                    ren,
  input  logic                    wen,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] strobe,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    error,
  output logic                    request_stall
);

  localparam int unsigned WORD_AW = MEM_BYTE_WIDTH - 2;
  localparam logic [LAT_W-1:0] RD_LAT = LAT_W'(READ_LATENCY);
  localparam logic [LAT_W-1:0] WR_LAT = LAT_W'(WRITE_LATENCY);

  state_t                  r_state, w_next;
  logic [LAT_W-1:0]        r_cnt, w_cnt_next;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [DATA_WIDTH/8-1:0] r_strobe;
  req_kind_t               r_kind;

  logic             w_req, w_invalid, w_changed, w_latch;
  logic             w_stall, w_err, w_rd_en, w_we, w_use_latched;
  req_kind_t        w_kind;
  logic [LAT_W-1:0] w_lat;
  logic [31:0]      w_arr_rdata;

  assign w_req     = ren | wen;
  assign w_kind    = wen ? WRITE : READ;
  assign w_lat     = (w_kind == WRITE) ? WR_LAT : RD_LAT;
  assign w_invalid = (ren & wen) | (addr[1:0] != 2'b00) |
                     (addr[ADDR_WIDTH-1:MEM_BYTE_WIDTH] != '0);
  assign w_changed = (addr != r_addr) | (w_kind != r_kind) | (wdata != r_wdata);

  always_comb begin
    w_next        = r_state;
    w_cnt_next    = r_cnt;
    w_latch       = 1'b0;
    w_stall       = 1'b0;
    w_err         = 1'b0;
    w_rd_en       = 1'b0;
    w_we          = 1'b0;
    w_use_latched = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          if (w_invalid) begin
            w_err = 1'b1;
          end else if (w_lat == '0) begin
            // Zero latency completes straight from the bus inputs.
            w_we    = (w_kind == WRITE);
            w_rd_en = (w_kind == READ);
          end else begin
            w_latch    = 1'b1;
            w_stall    = 1'b1;
            w_cnt_next = w_lat;
            w_next     = (w_lat == LAT_W'(1)) ? DONE : WAIT;
          end
        end
      end
      WAIT: begin
        if (!w_req) begin
          w_next     = IDLE;
          w_cnt_next = '0;
        end else if (w_changed) begin
          w_stall    = 1'b1;
          w_next     = IDLE;
          w_cnt_next = '0;
        end else begin
          w_stall    = 1'b1;
          w_cnt_next = r_cnt - LAT_W'(1);
          if (r_cnt == LAT_W'(2)) w_next = DONE;
        end
      end
      DONE: begin
        w_use_latched = 1'b1;
        w_we          = (r_kind == WRITE);
        w_rd_en       = (r_kind == READ);
        w_next        = IDLE;
        w_cnt_next    = '0;
      end
      default: begin
        w_next     = IDLE;
        w_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_strobe <= '0;
      r_kind   <= READ;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (w_latch) begin
        r_addr   <= addr;
        r_wdata  <= wdata;
        r_strobe <= strobe;
        r_kind   <= w_kind;
      end
    end
  end

  vortex_mem_slave_array #(
    .AW (WORD_AW)
  ) u_array (
    .CLK   (CLK),
    .we    (w_we & nRST),
    .be    (w_use_latched ? r_strobe : strobe),
    .waddr (w_use_latched ? r_addr[MEM_BYTE_WIDTH-1:2] : addr[MEM_BYTE_WIDTH-1:2]),
    .wdata (w_use_latched ? r_wdata : wdata),
    .raddr (w_use_latched ? r_addr[MEM_BYTE_WIDTH-1:2] : addr[MEM_BYTE_WIDTH-1:2]),
    .rdata (w_arr_rdata)
  );

  // Outputs are gated by nRST so they read 0 throughout reset.
  assign request_stall = nRST & w_stall;
  assign error         = nRST & w_err;
  assign rdata         = (nRST & w_rd_en) ? w_arr_rdata : '0;

endmodule

// File: tb/tb_vortex_mem_slave.sv
// Bench for vortex_mem_slave: three latency configurations sharing one bus.
module tb_vortex_mem_slave;

  localparam int unsigned RL0 = 2, WL0 = 1;
  localparam int unsigned RL1 = 4, WL1 = 3;
  localparam int unsigned RL2 = 0, WL2 = 0;

  if (RL0 > 15 || WL0 > 15 || RL1 > 15 || WL1 > 15 || RL2 > 15 || WL2 > 15) begin : g_lat_chk
    $error("latency parameter above 15");
  end

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ren, wen;
  logic [1:0]  sel;
  logic [31:0] addr, wdata;
  logic [3:0]  strobe;
  logic [2:0]  ren_v, wen_v, err_v, st_v;
  logic [31:0] rd_v [3];

  assign ren_v = ren ? (3'b001 << sel) : 3'b000;
  assign wen_v = wen ? (3'b001 << sel) : 3'b000;

  always #5 CLK = ~CLK;

  vortex_mem_slave #(.READ_LATENCY(RL0), .WRITE_LATENCY(WL0)) u_d0 (
    .CLK(CLK), .nRST(nRST), .ren(ren_v[0]), .wen(wen_v[0]), .addr(addr), .wdata(wdata),
    .strobe(strobe), .rdata(rd_v[0]), .error(err_v[0]), .request_stall(st_v[0]));
  vortex_mem_slave #(.READ_LATENCY(RL1), .WRITE_LATENCY(WL1)) u_d1 (
    .CLK(CLK), .nRST(nRST), .ren(ren_v[1]), .wen(wen_v[1]), .addr(addr), .wdata(wdata),
    .strobe(strobe), .rdata(rd_v[1]), .error(err_v[1]), .request_stall(st_v[1]));
  vortex_mem_slave #(.READ_LATENCY(RL2), .WRITE_LATENCY(WL2)) u_d2 (
    .CLK(CLK), .nRST(nRST), .ren(ren_v[2]), .wen(wen_v[2]), .addr(addr), .wdata(wdata),
    .strobe(strobe), .rdata(rd_v[2]), .error(err_v[2]), .request_stall(st_v[2]));

  typedef struct {
    int unsigned d;
    logic        r, w;
    logic [31:0] a, dat;
    logic [3:0]  s;
    int unsigned stalls;
    logic        err;
    logic [31:0] rd;
  } vec_t;

  typedef struct {
    string       name;
    int unsigned stalls;
    logic        err;
    logic [31:0] rd;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(int unsigned d, logic r, logic w, logic [31:0] a, logic [31:0] dat,
                              logic [3:0] s, int unsigned stalls, logic err, logic [31:0] rd);
    vec_t v;
    v.d = d; v.r = r; v.w = w; v.a = a; v.dat = dat; v.s = s;
    v.stalls = stalls; v.err = err; v.rd = rd;
    return v;
  endfunction

  task automatic start_req(input int unsigned d, input logic r, input logic w, input logic [31:0] a,
                           input logic [31:0] dat, input logic [3:0] s);
    sel = d[1:0]; ren = r; wen = w; addr = a; wdata = dat; strobe = s;
  endtask

  task automatic push_exp(input string nm, input int unsigned stalls, input logic err,
                          input logic [31:0] rd);
    exp_t e;
    e.name = nm; e.stalls = stalls; e.err = err; e.rd = rd;
    sb.push_back(e);
  endtask

  // Called 1 time unit after a rising edge; samples mid-cycle until completion.
  task automatic finish_req(input int unsigned d);
    int unsigned n = 0;
    bit          done = 0;
    bit          leak = 0;
    logic [31:0] grd = '0;
    logic        gerr = 1'b0;
    exp_t        e;
    for (int c = 0; c < 40 && !done; c++) begin
      #4;
      if (st_v[d]) begin
        n++;
        if (rd_v[d] !== 32'h0 || err_v[d] !== 1'b0) leak = 1;
      end else begin
        done = 1; grd = rd_v[d]; gerr = err_v[d];
      end
      @(posedge CLK); #1;
    end
    ren = 1'b0; wen = 1'b0;
    e = sb.pop_front();
    if (!done) begin
      checks++; failures++;
      $display("FAIL %s timeout: no completion within 40 cycles", e.name);
    end else begin
      chk({e.name, " stalls"}, n, e.stalls);
      chk({e.name, " error"}, {31'h0, gerr}, {31'h0, e.err});
      chk({e.name, " rdata"}, grd, e.rd);
      chk({e.name, " quiet_while_stalled"}, {31'h0, leak}, 32'h0);
    end
  endtask

  task automatic run_req(input string nm, input vec_t v);
    push_exp(nm, v.stalls, v.err, v.rd);
    start_req(v.d, v.r, v.w, v.a, v.dat, v.s);
    finish_req(v.d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl.push_back(mk(0, 1'b0, 1'b1, 32'h0010, 32'hDEADBEEF, 4'hF, 1, 1'b0, 32'h0));
    tbl.push_back(mk(0, 1'b1, 1'b0, 32'h0010, 32'h0,        4'h0, 2, 1'b0, 32'hDEADBEEF));
    tbl.push_back(mk(0, 1'b0, 1'b1, 32'h0020, 32'h11223344, 4'hF, 1, 1'b0, 32'h0));
    tbl.push_back(mk(0, 1'b0, 1'b1, 32'h0020, 32'hAABBCCDD, 4'h5, 1, 1'b0, 32'h0));
    tbl.push_back(mk(0, 1'b1, 1'b0, 32'h0020, 32'h0,        4'h0, 2, 1'b0, 32'h11BB33DD));
    tbl.push_back(mk(0, 1'b0, 1'b1, 32'h0000, 32'h55AA0001, 4'hF, 1, 1'b0, 32'h0));
    tbl.push_back(mk(0, 1'b1, 1'b0, 32'h4000, 32'h0,        4'h0, 0, 1'b1, 32'h0));
    tbl.push_back(mk(0, 1'b0, 1'b1, 32'h0002, 32'hFFFFFFFF, 4'hF, 0, 1'b1, 32'h0));
    tbl.push_back(mk(0, 1'b1, 1'b1, 32'h0000, 32'hFFFFFFFF, 4'hF, 0, 1'b1, 32'h0));
    tbl.push_back(mk(0, 1'b1, 1'b0, 32'h0000, 32'h0,        4'h0, 2, 1'b0, 32'h55AA0001));
    tbl.push_back(mk(0, 1'b0, 1'b1, 32'h3FFC, 32'h0BADF00D, 4'hF, 1, 1'b0, 32'h0));
    tbl.push_back(mk(0, 1'b1, 1'b0, 32'h3FFC, 32'h0,        4'h0, 2, 1'b0, 32'h0BADF00D));
    tbl.push_back(mk(0, 1'b0, 1'b1, 32'h0010, 32'h00000000, 4'h0, 1, 1'b0, 32'h0));
    tbl.push_back(mk(0, 1'b1, 1'b0, 32'h0010, 32'h0,        4'h0, 2, 1'b0, 32'hDEADBEEF));
    tbl.push_back(mk(2, 1'b0, 1'b1, 32'h0000, 32'h01020304, 4'hF, 0, 1'b0, 32'h0));
    tbl.push_back(mk(2, 1'b0, 1'b1, 32'h0004, 32'hA0B0C0D0, 4'hF, 0, 1'b0, 32'h0));
    tbl.push_back(mk(2, 1'b1, 1'b0, 32'h0000, 32'h0,        4'h0, 0, 1'b0, 32'h01020304));
    tbl.push_back(mk(2, 1'b1, 1'b0, 32'h0004, 32'h0,        4'h0, 0, 1'b0, 32'hA0B0C0D0));
    tbl.push_back(mk(2, 1'b1, 1'b0, 32'h0006, 32'h0,        4'h0, 0, 1'b1, 32'h0));
    tbl.push_back(mk(2, 1'b0, 1'b1, 32'h0004, 32'hFFFF0000, 4'hC, 0, 1'b0, 32'h0));
    tbl.push_back(mk(2, 1'b1, 1'b0, 32'h0004, 32'h0,        4'h0, 0, 1'b0, 32'hFFFFC0D0));
    tbl.push_back(mk(1, 1'b0, 1'b1, 32'h0010, 32'h600DCAFE, 4'hF, 3, 1'b0, 32'h0));
    tbl.push_back(mk(1, 1'b0, 1'b1, 32'h0030, 32'hCAFEF00D, 4'hF, 3, 1'b0, 32'h0));
    tbl.push_back(mk(1, 1'b1, 1'b0, 32'h0030, 32'h0,        4'h0, 4, 1'b0, 32'hCAFEF00D));

    // Outputs held at 0 during reset even with a request present.
    nRST = 1'b0;
    start_req(0, 1'b1, 1'b0, 32'h0000, 32'h0, 4'h0);
    #3;
    chk("reset stall", {31'h0, st_v[0]}, 32'h0);
    chk("reset error", {31'h0, err_v[0]}, 32'h0);
    chk("reset rdata", rd_v[0], 32'h0);
    ren = 1'b0;
    #9 nRST = 1'b1;
    @(posedge CLK); #1;
    #4;
    chk("idle stall", {29'h0, st_v}, 32'h0);
    chk("idle rdata", rd_v[0], 32'h0);
    @(posedge CLK); #1;

    foreach (tbl[i]) run_req($sformatf("vec%0d", i), tbl[i]);

    // Abort: read withdrawn in its third cycle never completes.
    start_req(1, 1'b1, 1'b0, 32'h0010, 32'h0, 4'h0);
    #4 chk("abort c0 stall", {31'h0, st_v[1]}, 32'h1);
    @(posedge CLK); #1;
    #4 chk("abort c1 stall", {31'h0, st_v[1]}, 32'h1);
    @(posedge CLK); #1;
    ren = 1'b0;
    #4 chk("abort c2 stall", {31'h0, st_v[1]}, 32'h0);
    chk("abort c2 rdata", rd_v[1], 32'h0);
    @(posedge CLK); #1;
    #4 chk("abort c3 rdata", rd_v[1], 32'h0);
    chk("abort c3 error", {31'h0, err_v[1]}, 32'h0);
    @(posedge CLK); #1;
    run_req("abort reread", mk(1, 1'b1, 1'b0, 32'h0010, 32'h0, 4'h0, 4, 1'b0, 32'h600DCAFE));

    // Address changed mid-WAIT: one stall cycle to abort, then a full restart.
    start_req(1, 1'b1, 1'b0, 32'h0040, 32'h0, 4'h0);
    #4 chk("change c0 stall", {31'h0, st_v[1]}, 32'h1);
    @(posedge CLK); #1;
    push_exp("change restart", 5, 1'b0, 32'h600DCAFE);
    addr = 32'h0010;
    finish_req(1);

    // Reset during a write: outputs drop at once and the write is lost.
    start_req(1, 1'b0, 1'b1, 32'h0030, 32'h12345678, 4'hF);
    #4 chk("rstwr c0 stall", {31'h0, st_v[1]}, 32'h1);
    @(posedge CLK); #1;
    nRST = 1'b0;
    #1;
    chk("rstwr stall", {31'h0, st_v[1]}, 32'h0);
    chk("rstwr error", {31'h0, err_v[1]}, 32'h0);
    chk("rstwr rdata", rd_v[1], 32'h0);
    wen = 1'b0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    nRST = 1'b1;
    @(posedge CLK); #1;
    run_req("rstwr readback", mk(1, 1'b1, 1'b0, 32'h0030, 32'h0, 4'h0, 4, 1'b0, 32'hCAFEF00D));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
